di_fifo_terminal: RTL and testbench
===================================

# di_fifo_terminal

Loopback FIFO terminal on the di_* bus, directly downstream of HostInterface. Host writes to its terminal address push 16-bit words into on-chip RAM; host reads pop them in order through a prefetching output stage sustaining one word per ifclk. It exports di_reg_datao, di_read_rdy, di_write_rdy and di_transfer_status for the top-level terminal mux, with sticky overflow/underflow flags and a flush control.

## Interface
- TERM_ADDR, 16'h0010, terminal address this block responds to
- DEPTH_LOG2, 9, log2 of RAM depth (512 words)
- ifclk  in  1  clock (all logic)
- resetb  in  1  reset; one clock, reset asynchronous and active-low
- di_term_addr  in  16  selected terminal
- di_reg_addr  in  32  register address; bit 31 marks a control write
- di_read_req  in  1  host will read next cycle
- di_read  in  1  host consumes di_reg_datao this cycle
- di_write  in  1  host presents di_reg_datai this cycle
- di_reg_datai  in  16  write data
- di_reg_datao  out  16  read data
- di_read_rdy  out  1  di_reg_datao valid
- di_write_rdy  out  1  a push will be accepted
- di_transfer_status  out  16  {13'b0, ovf, unf, empty}
- fill_level  out  DEPTH_LOG2+1  words held (RAM + output stages)

## Operation
- sel = (di_term_addr == TERM_ADDR); di_read/di_write ignored when !sel.
- Push: sel & di_write & !di_reg_addr[31] & !full -> mem[wptr] <= di_reg_datai, wptr++.
- Overflow: same but full -> word dropped, ovf <= 1.
- Control write: sel & di_write & di_reg_addr[31]: datai[0] = flush (wptr, rptr, level, both stage valids <= 0); datai[1] = clear ovf/unf. Never pushed, never sets ovf.
- Output stage: RAM read register (s1) feeding output register (s0). Issue RAM read when !empty_ram and s1 will be free; s1 -> s0 when s0 empty or consumed. di_reg_datao = s0 data; di_read_rdy = s0 valid.
- Pop: sel & di_read & di_read_rdy -> s0 advances (refilled same cycle from s1 if valid).
- Underflow: sel & di_read & !di_read_rdy -> unf <= 1, di_reg_datao unchanged.
- di_read_req: informational only; no state change.
- level: +1 on accepted push, -1 on pop, unchanged when both. full = (level == 2^DEPTH_LOG2); di_write_rdy = !full, from registered level. empty = (level == 0).
- Pointers are DEPTH_LOG2 bits, wrap modulo depth without special handling.
- Reset (any time, including mid-transfer): pointers, level, s0/s1 valid, ovf, unf <= 0; di_reg_datao <= 0; di_read_rdy 0; di_write_rdy 1; status 16'h0001; RAM contents undefined, not reset.

## Timing
- RAM: synchronous read, 1-cycle latency.
- Push at edge N into empty FIFO -> di_read_rdy high after edge N+2 (two-cycle latency).
- Sustained: one pop per cycle with di_read held high while level ≥ 2; no bubbles.
- Flush takes effect at the edge it is sampled; a simultaneous pop is discarded; di_read_rdy low next cycle.
- Simultaneous push and pop when full: push refused (write_rdy already 0), pop completes; write_rdy high next cycle.
- Status and fill_level registered, updated the cycle after the causing event.

## Structure
- Shared package: TERM_ADDR constant for this terminal, status bit indices (EMPTY=0, UNF=1, OVF=2), control bit indices (FLUSH=0, CLR=1).
- Sub-module di_fifo_ram: simple dual-port RAM, one write port, one synchronous read port, parameterized by DEPTH_LOG2 and width 16.
- Top module holds pointers, level counter, two-stage output pipeline, flags.

## Test plan
- Reset then write 16'h1234, 16'h5678 -> di_read_rdy high 2 cycles after first push; two pops return 16'h1234, 16'h5678; status returns to 16'h0001.
- Write 512 words 0..511 -> di_write_rdy 0, fill_level 512; 513th write -> dropped, status bit 2 set; read back 0..511 one per cycle, no gaps.
- di_read on empty FIFO -> status 16'h0003, datao unchanged; control write addr 32'h8000_0000 data 16'h0002 -> status 16'h0001.
- Fill 100 words, control write data 16'h0001 -> fill_level 0, di_read_rdy 0 next cycle, next pushed word reads back first.
- Pointer wrap: 3×(push 300, pop 300) with incrementing data -> all 900 words in order, level 0 at end.
- Assert resetb low mid-burst (level 50, rdy high) -> outputs at reset values immediately; after release FIFO empty and write_rdy 1.

Source files
------------

// File: rtl/di_fifo_terminal_pkg.sv
// Shared constants for the di_fifo_terminal loopback FIFO.
//   FIFO_TERM_ADDR : di_term_addr value this terminal answers to
//   STAT_*         : bit positions inside di_transfer_status
//   CTRL_*         : bit positions inside a control-write data word
package di_fifo_terminal_pkg;

  localparam logic [15:0] FIFO_TERM_ADDR = 16'h0010;

  localparam int unsigned STAT_EMPTY = 0;
  localparam int unsigned STAT_UNF   = 1;
  localparam int unsigned STAT_OVF   = 2;

  localparam int unsigned CTRL_FLUSH = 0;
  localparam int unsigned CTRL_CLR   = 1;

endpackage

// File: rtl/di_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port
//   i_re/i_raddr     read enable/address; o_rdata updates one clock later
//   o_rdata          registered read data, held while i_re is low
// Contents are never reset.
module di_fifo_ram #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read data must hold while the downstream stage is stalled.
  always_ff @(posedge i_clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/di_fifo_terminal.sv
// Loopback FIFO terminal on the di_* bus. Host writes push 16-bit words into
// RAM; host reads pop them in order through a two-stage prefetch pipeline
// (s1 = RAM read register, s0 = output register) giving one word per clock.
// Ports:
//   ifclk, resetb          clock, asynchronous active-low reset
//   di_term_addr           selected terminal (compared with TERM_ADDR)
//   di_reg_addr            bit 31 marks a control write
//   di_read_req            informational only
//   di_read / di_write     pop / push (or control) strobes
//   di_reg_datai           write data
//   di_reg_datao           read data (s0)
//   di_read_rdy            s0 valid
//   di_write_rdy           FIFO not full
//   di_transfer_status     {13'b0, ovf, unf, empty}
//   fill_level             words held in RAM plus both output stages
module di_fifo_terminal
  import di_fifo_terminal_pkg::*;
#(
  parameter logic [15:0] TERM_ADDR  = FIFO_TERM_ADDR,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  ifclk,
  input  logic                  resetb,
  input  logic [15:0]           di_term_addr,
  input  logic [31:0]           di_reg_addr,
  input  logic                  di_read_req,
  input  logic                  di_read,
  input  logic                  di_write,
  input  logic [15:0]           di_reg_datai,
  output logic [15:0]           di_reg_datao,
  output logic                  di_read_rdy,
  output logic                  di_write_rdy,
  output logic [15:0]           di_transfer_status,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr, w_wptr_nxt, w_rptr_nxt;
  logic [LVL_W-1:0]      r_level, r_ram_cnt, w_level_nxt, w_ram_cnt_nxt;
  logic                  r_s0_vld, r_s1_vld, w_s0_vld_nxt, w_s1_vld_nxt;
  logic [15:0]           r_s0_data, w_s0_data_nxt;
  logic                  r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
  logic [15:0]           w_ram_rdata;

  logic w_sel, w_full, w_empty, w_ctrl, w_data_wr, w_push, w_ovf_set;
  logic w_flush, w_clr, w_pop, w_unf_set, w_s0_load, w_s1_free, w_rd_issue;
  logic w_unused;

  assign w_unused = ^{di_read_req, di_reg_addr[30:0]};

  assign w_sel     = (di_term_addr == TERM_ADDR);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_ctrl    = w_sel & di_write & di_reg_addr[31];
  assign w_data_wr = w_sel & di_write & ~di_reg_addr[31];
  assign w_push    = w_data_wr & ~w_full;
  assign w_ovf_set = w_data_wr & w_full;
  assign w_flush   = w_ctrl & di_reg_datai[CTRL_FLUSH];
  assign w_clr     = w_ctrl & di_reg_datai[CTRL_CLR];
  assign w_pop     = w_sel & di_read & r_s0_vld;
  assign w_unf_set = w_sel & di_read & ~r_s0_vld;

  // s1 moves into s0 when s0 is empty or being consumed this cycle.
  assign w_s0_load  = r_s1_vld & (~r_s0_vld | w_pop);
  // A new RAM read may overwrite s1 only if s1 is empty or draining now.
  assign w_s1_free  = ~r_s1_vld | w_s0_load;
  assign w_rd_issue = (r_ram_cnt != '0) & w_s1_free;

  di_fifo_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_ram (
    .i_clk   (ifclk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (di_reg_datai),
    .i_re    (w_rd_issue),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_wptr_nxt    = r_wptr + DEPTH_LOG2'(w_push);
    w_rptr_nxt    = r_rptr + DEPTH_LOG2'(w_rd_issue);
    w_ram_cnt_nxt = r_ram_cnt + LVL_W'(w_push) - LVL_W'(w_rd_issue);
    w_level_nxt   = r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    w_s0_vld_nxt  = r_s0_vld;
    w_s0_data_nxt = r_s0_data;
    w_s1_vld_nxt  = r_s1_vld;

    if (w_s0_load) begin
      w_s0_vld_nxt  = 1'b1;
      w_s0_data_nxt = w_ram_rdata;
    end else if (w_pop) begin
      w_s0_vld_nxt  = 1'b0;
    end

    if (w_rd_issue)     w_s1_vld_nxt = 1'b1;
    else if (w_s0_load) w_s1_vld_nxt = 1'b0;

    // Flush discards everything in flight, including a simultaneous pop.
    // Output data register keeps its last value.
    if (w_flush) begin
      w_wptr_nxt    = '0;
      w_rptr_nxt    = '0;
      w_ram_cnt_nxt = '0;
      w_level_nxt   = '0;
      w_s0_vld_nxt  = 1'b0;
      w_s0_data_nxt = r_s0_data;
      w_s1_vld_nxt  = 1'b0;
    end

    w_ovf_nxt = w_clr ? 1'b0 : (r_ovf | w_ovf_set);
    w_unf_nxt = w_clr ? 1'b0 : (r_unf | w_unf_set);
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_level   <= '0;
      r_s0_vld  <= 1'b0;
      r_s0_data <= '0;
      r_s1_vld  <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_level   <= w_level_nxt;
      r_s0_vld  <= w_s0_vld_nxt;
      r_s0_data <= w_s0_data_nxt;
      r_s1_vld  <= w_s1_vld_nxt;
      r_ovf     <= w_ovf_nxt;
      r_unf     <= w_unf_nxt;
    end
  end

  always_comb begin
    di_transfer_status             = '0;
    di_transfer_status[STAT_EMPTY] = w_empty;
    di_transfer_status[STAT_UNF]   = r_unf;
    di_transfer_status[STAT_OVF]   = r_ovf;
  end

  assign di_reg_datao = r_s0_data;
  assign di_read_rdy  = r_s0_vld;
  assign di_write_rdy = ~w_full;
  assign fill_level   = r_level;

endmodule

// File: tb/tb_di_fifo_terminal.sv
module tb_di_fifo_terminal;

  localparam logic [15:0] TERM = 16'h0010;

  logic        ifclk = 1'b0;
  logic        resetb;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_read_req;
  logic        di_read;
  logic        di_write;
  logic [15:0] di_reg_datai;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy;
  logic        di_write_rdy;
  logic [15:0] di_transfer_status;
  logic [9:0]  fill_level;

  int checks = 0;
  int errors = 0;

  // Scoreboard and independent model state
  logic [15:0] sb_q[$];
  int          m_level = 0;
  logic [15:0] m_last = 16'h0000;

  di_fifo_terminal dut (
    .ifclk              (ifclk),
    .resetb             (resetb),
    .di_term_addr       (di_term_addr),
    .di_reg_addr        (di_reg_addr),
    .di_read_req        (di_read_req),
    .di_read            (di_read),
    .di_write           (di_write),
    .di_reg_datai       (di_reg_datai),
    .di_reg_datao       (di_reg_datao),
    .di_read_rdy        (di_read_rdy),
    .di_write_rdy       (di_write_rdy),
    .di_transfer_status (di_transfer_status),
    .fill_level         (fill_level)
  );

  always #5 ifclk = ~ifclk;

  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    di_term_addr = TERM;
    di_reg_addr  = 32'h0;
    di_write     = 1'b1;
    di_reg_datai = d;
    if (m_level < 512) begin
      sb_q.push_back(d);
      m_level++;
    end
    step();
    di_write = 1'b0;
  endtask

  task automatic ctrl_write(input logic [15:0] d);
    di_term_addr = TERM;
    di_reg_addr  = 32'h8000_0000;
    di_write     = 1'b1;
    di_reg_datai = d;
    step();
    di_write    = 1'b0;
    di_reg_addr = 32'h0;
  endtask

  // Pops n words, comparing each against the scoreboard head.
  task automatic drain(input int n, input bit no_gaps, input string name);
    int got = 0;
    int waited = 0;
    logic [15:0] exp;
    while (got < n && waited < n + 20) begin
      if (di_read_rdy) begin
        di_read = 1'b1;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra word: got %h, required none", name, di_reg_datao);
        end else begin
          exp = sb_q.pop_front();
          m_level--;
          m_last = exp;
          if (di_reg_datao !== exp) begin
            errors++;
            $display("FAIL %s word %0d: got %h, required %h", name, got, di_reg_datao, exp);
          end
        end
        got++;
      end else begin
        di_read = 1'b0;
        if (no_gaps && got > 0) begin
          checks++;
          errors++;
          $display("FAIL %s bubble after word %0d: read_rdy got 0, required 1", name, got);
        end
      end
      step();
      waited++;
    end
    di_read = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, got, n);
    end
  endtask

  task automatic check_idle(input string name, input logic [15:0] exp_status);
    checks++;
    if (di_read_rdy !== 1'b0 || di_write_rdy !== 1'b1 || fill_level !== 10'(m_level)
        || di_transfer_status !== exp_status) begin
      errors++;
      $display("FAIL %s: rdy=%b wrdy=%b fill=%0d status=%h, required rdy=0 wrdy=1 fill=%0d status=%h",
               name, di_read_rdy, di_write_rdy, fill_level, di_transfer_status, m_level, exp_status);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    #3;
    checks++;
    if (di_reg_datao !== 16'h0) begin
      errors++;
      $display("FAIL reset datao: got %h, required 0000", di_reg_datao);
    end
    check_idle("reset", 16'h0001);
    step(); step();
    resetb = 1'b1;
    step();
    check_idle("post_reset", 16'h0001);
  endtask

  task automatic test_basic();
    push_word(16'h1234);
    push_word(16'h5678);
    checks++;
    if (di_read_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic early rdy: got %b, required 0", di_read_rdy);
    end
    step();
    checks++;
    if (di_read_rdy !== 1'b1) begin
      errors++;
      $display("FAIL basic latency rdy: got %b, required 1", di_read_rdy);
    end
    drain(2, 1'b1, "basic");
    check_idle("basic_end", 16'h0001);
  endtask

  task automatic test_unselected();
    di_term_addr = 16'h0011;
    di_reg_addr  = 32'h0;
    di_write     = 1'b1;
    di_reg_datai = 16'hDEAD;
    di_read      = 1'b1;
    step();
    di_write     = 1'b0;
    di_read      = 1'b0;
    di_term_addr = TERM;
    check_idle("unselected", 16'h0001);
  endtask

  task automatic test_full();
    for (int i = 0; i < 512; i++) push_word(16'(i));
    step();
    checks++;
    if (di_write_rdy !== 1'b0 || fill_level !== 10'd512) begin
      errors++;
      $display("FAIL full: wrdy=%b fill=%0d, required wrdy=0 fill=512", di_write_rdy, fill_level);
    end
    push_word(16'hFFFF);
    checks++;
    if (di_transfer_status !== 16'h0004 || fill_level !== 10'd512) begin
      errors++;
      $display("FAIL overflow: status=%h fill=%0d, required status=0004 fill=512",
               di_transfer_status, fill_level);
    end
    drain(512, 1'b1, "full_drain");
    check_idle("full_end", 16'h0005);
    ctrl_write(16'h0002);
    check_idle("ovf_clear", 16'h0001);
  endtask

  task automatic test_underflow();
    di_term_addr = TERM;
    di_read      = 1'b1;
    step();
    di_read = 1'b0;
    checks++;
    if (di_transfer_status !== 16'h0003 || di_reg_datao !== m_last) begin
      errors++;
      $display("FAIL underflow: status=%h datao=%h, required status=0003 datao=%h",
               di_transfer_status, di_reg_datao, m_last);
    end
    ctrl_write(16'h0002);
    check_idle("unf_clear", 16'h0001);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 100; i++) push_word(16'hA000 + 16'(i));
    step();
    ctrl_write(16'h0001);
    sb_q.delete();
    m_level = 0;
    check_idle("flush", 16'h0001);
    push_word(16'hBEEF);
    drain(1, 1'b0, "flush_next");
    check_idle("flush_end", 16'h0001);
  endtask

  task automatic test_wrap();
    logic [15:0] d = 16'h1000;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 300; i++) begin
        push_word(d);
        d++;
      end
      drain(300, 1'b1, "wrap");
    end
    check_idle("wrap_end", 16'h0001);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 60; i++) push_word(16'h3000 + 16'(i));
    step();
    drain(10, 1'b1, "mid_pre");
    checks++;
    if (fill_level !== 10'd50 || di_read_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_level: fill=%0d rdy=%b, required fill=50 rdy=1", fill_level, di_read_rdy);
    end
    di_read = 1'b1;
    #2 resetb = 1'b0;
    #1;
    di_read = 1'b0;
    sb_q.delete();
    m_level = 0;
    checks++;
    if (di_reg_datao !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset datao: got %h, required 0000", di_reg_datao);
    end
    check_idle("mid_reset", 16'h0001);
    step(); step();
    resetb = 1'b1;
    step();
    check_idle("mid_release", 16'h0001);
    push_word(16'h5A5A);
    drain(1, 1'b0, "mid_after");
  endtask

  initial begin
    resetb       = 1'b1;
    di_term_addr = TERM;
    di_reg_addr  = 32'h0;
    di_read_req  = 1'b0;
    di_read      = 1'b0;
    di_write     = 1'b0;
    di_reg_datai = 16'h0;
    #1;
    test_reset();
    test_basic();
    test_unselected();
    test_full();
    test_underflow();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
